sonic_eth_10g_tx_frame_arbiter: RTL and testbench
=================================================

Name: sonic_eth_10g_tx_frame_arbiter

Overview:
- Shares the 10G MAC TX Avalon-ST frame interface between two packet sources, e.g. host DMA and a local test/pause-frame generator.
- Sits directly upstream of the MAC TX timing adapter / frame decoder.
- Arbitrates per packet, round-robin, and holds the grant from SOP to EOP.
- Provides one registered output stage, drops stray beats, and keeps per-port statistics.

Parameters:
- DATA_W, 64, data beat width.
- ERROR_W, 3, error sideband width.
- EMPTY_W, 3, empty-byte count width.
- CNT_W, 16, width of statistics counters.

Ports:
- clk  input  1  single clock for all logic.
- reset_n  input  1  reset, asynchronous assert, active-low.
- in0_valid / in1_valid  input  1  per-port beat valid.
- in0_ready / in1_ready  output  1  per-port ready, ready latency 0.
- in0_data / in1_data  input  DATA_W  beat data.
- in0_error / in1_error  input  ERROR_W  error sideband.
- in0_startofpacket / in1_startofpacket  input  1  SOP.
- in0_endofpacket / in1_endofpacket  input  1  EOP.
- in0_empty / in1_empty  input  EMPTY_W  empty bytes, meaningful on EOP.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready, ready latency 0.
- out_data, out_error, out_startofpacket, out_endofpacket, out_empty  output  matching widths  registered payload.
- pkt_cnt0 / pkt_cnt1  output  CNT_W  EOP beats forwarded per port, wrapping.
- drop_cnt  output  CNT_W  stray beats discarded, saturating at all-ones.
- owner  output  2  one-hot current grant; 00 when idle.

Behaviour:
- Reset values (reset_n low, asynchronous):
  - state IDLE, owner=00, last_grant=port1 so port0 wins the first tie.
  - out_valid=0, all out_* payload bits 0, all counters 0, in*_ready=0.
- States:
  - IDLE: no port granted.
  - OWN0: port0 owns the output.
  - OWN1: port1 owns the output.
- Request definition: in*_valid AND in*_startofpacket.
- IDLE transitions:
  - One request: go to that port's OWN state next cycle.
  - Both request: grant the port != last_grant, go to its OWN state next cycle, update last_grant to the granted port.
  - No beat is transferred in the IDLE cycle.
  - Grant takes effect the cycle after the request, so there is a 1-cycle arbitration bubble.
- Stray beats in IDLE:
  - A valid beat without SOP on a port is discarded: that port's in*_ready=1 that cycle, drop_cnt += 1 (saturating).
  - Discards on both ports in the same cycle add 2, still saturating.
  - The same port cannot both request and be dropped in one cycle.
- OWNx behaviour:
  - accept = inx_valid AND (NOT out_valid OR out_ready).
  - inx_ready = NOT out_valid OR out_ready, independent of inx_valid.
  - Non-owner ready = 0.
  - On accept: output register loads inx payload and out_valid=1.
  - If out_ready=1 with no accept: out_valid clears.
  - If out_valid=0 or out_ready=0 with no accept: register holds.
  - Accept with endofpacket=1: pkt_cntx += 1 (wrapping); next state IDLE.
  - A SOP+EOP single-beat packet grants, transfers, and returns to IDLE.
- Latency: request at cycle N → grant N+1 → out_valid with SOP at N+2 if out_ready stays high. Steady state is 1 beat/cycle inside a packet.
- Backpressure: the output payload is stable while out_valid=1 and out_ready=0. No beat is lost or duplicated.
- SOP seen mid-packet from the owner: forwarded unchanged. The arbiter does not repair framing; the MAC flags it.
- Owner deasserting valid mid-packet: grant is kept indefinitely (no timeout) and the other port waits.
- Arbiter idle with out_valid=1 and out_ready=0: the pending beat remains valid.
- Reset asserted mid-packet: immediate return to reset values; the partial frame is abandoned and out_valid drops.

Decomposition:
- Shared package (sonic_eth_10g_pkg):
  - Arbiter state enum: IDLE, OWN0, OWN1.
  - Width constants: DATA_W=64, ERROR_W=3, EMPTY_W=3.
  - Packed Avalon-ST beat struct {data, error, sop, eop, empty} of 72 bits, same field order as the MAC TX payload.
- Natural sub-module: sonic_eth_10g_st_pipe_stage, a one-entry registered Avalon-ST stage holding the beat struct and implementing the accept/hold/clear rule above.
- Arbiter FSM, payload mux and counters stay in the top module.

Test Plan:
- Port0 sends a 3-beat packet (data 0x11,0x22,0x33, eop empty=5), out_ready=1 → out_valid at N+2, 3 consecutive beats, out_empty=5 on last, pkt_cnt0=1, owner returns to 00.
- Both ports assert SOP in the same cycle after reset → port0 fully forwarded first, then port1; on the next simultaneous request port1 wins.
- Port1 packet with out_ready toggling 1,0,0,1 mid-packet → payload held stable while stalled, no beat duplicated or lost, in1_ready=0 during the stall.
- In IDLE, port0 presents 4 non-SOP beats → in0_ready=1 each cycle, nothing on out, drop_cnt=4; preset drop_cnt near 0xFFFF and confirm it saturates at 0xFFFF.
- Single-beat packets (SOP+EOP) back-to-back on both ports → alternating grants, pkt_cnt0 = pkt_cnt1 = number sent, one IDLE bubble between packets.
- reset_n pulsed low during beat 2 of a 4-beat port0 packet → out_valid=0, owner=00, counters=0 immediately, and a following port1 packet is forwarded cleanly.

Source files
------------

// File: rtl/sonic_eth_10g_pkg.sv
// rtl/sonic_eth_10g_pkg.sv - shared types and widths for the 10G MAC TX frame path
package sonic_eth_10g_pkg;

    localparam int DATA_W  = 64;
    localparam int ERROR_W = 3;
    localparam int EMPTY_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Field order mirrors the MAC TX payload: {data, error, sop, eop, empty}.
    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [ERROR_W-1:0] error;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
    } st_beat_t;

    localparam int BEAT_W = $bits(st_beat_t);

    function automatic logic [1:0] state_to_owner(input arb_state_t s);
        case (s)
            OWN0:    return 2'b01;
            OWN1:    return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/sonic_eth_10g_st_pipe_stage.sv
// rtl/sonic_eth_10g_st_pipe_stage.sv - one-entry registered Avalon-ST beat stage
module sonic_eth_10g_st_pipe_stage
    import sonic_eth_10g_pkg::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     i_s_valid,
    output logic     o_s_ready,
    input  st_beat_t i_s_beat,
    output logic     o_m_valid,
    input  logic     i_m_ready,
    output st_beat_t o_m_beat
);

    logic     r_valid;
    st_beat_t r_beat;
    logic     w_load;

    // Ready does not depend on i_s_valid, so upstream may wait on it safely.
    assign o_s_ready = ~r_valid | i_m_ready;
    assign w_load    = i_s_valid & o_s_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_beat  <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_beat  <= i_s_beat;
        end else if (i_m_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_m_valid = r_valid;
    assign o_m_beat  = r_beat;

endmodule

// File: rtl/sonic_eth_10g_tx_frame_arbiter.sv
// rtl/sonic_eth_10g_tx_frame_arbiter.sv - packet-level round-robin arbiter for two MAC TX sources
module sonic_eth_10g_tx_frame_arbiter #(
    parameter int DATA_W  = sonic_eth_10g_pkg::DATA_W,
    parameter int ERROR_W = sonic_eth_10g_pkg::ERROR_W,
    parameter int EMPTY_W = sonic_eth_10g_pkg::EMPTY_W,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in0_valid,
    output logic               in0_ready,
    input  logic [DATA_W-1:0]  in0_data,
    input  logic [ERROR_W-1:0] in0_error,
    input  logic               in0_startofpacket,
    input  logic               in0_endofpacket,
    input  logic [EMPTY_W-1:0] in0_empty,
    input  logic               in1_valid,
    output logic               in1_ready,
    input  logic [DATA_W-1:0]  in1_data,
    input  logic [ERROR_W-1:0] in1_error,
    input  logic               in1_startofpacket,
    input  logic               in1_endofpacket,
    input  logic [EMPTY_W-1:0] in1_empty,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [ERROR_W-1:0] out_error,
    output logic               out_startofpacket,
    output logic               out_endofpacket,
    output logic [EMPTY_W-1:0] out_empty,
    output logic [CNT_W-1:0]   pkt_cnt0,
    output logic [CNT_W-1:0]   pkt_cnt1,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic [1:0]         owner
);

    import sonic_eth_10g_pkg::*;

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic             r_last_grant;
    logic             w_last_grant_nxt;
    logic [CNT_W-1:0] r_pkt_cnt0;
    logic [CNT_W-1:0] r_pkt_cnt1;
    logic [CNT_W-1:0] r_drop_cnt;

    st_beat_t         w_beat0;
    st_beat_t         w_beat1;
    st_beat_t         w_s_beat;
    st_beat_t         w_out_beat;
    logic             w_s_valid;
    logic             w_s_ready;
    logic             w_req0;
    logic             w_req1;
    logic             w_drop0;
    logic             w_drop1;
    logic [1:0]       w_drop_inc;
    logic             w_pkt_inc0;
    logic             w_pkt_inc1;
    logic [CNT_W:0]   w_drop_sum;

    always_comb begin
        w_beat0       = '0;
        w_beat0.data  = in0_data;
        w_beat0.error = in0_error;
        w_beat0.sop   = in0_startofpacket;
        w_beat0.eop   = in0_endofpacket;
        w_beat0.empty = in0_empty;
        w_beat1       = '0;
        w_beat1.data  = in1_data;
        w_beat1.error = in1_error;
        w_beat1.sop   = in1_startofpacket;
        w_beat1.eop   = in1_endofpacket;
        w_beat1.empty = in1_empty;
    end

    assign w_req0  = in0_valid &  in0_startofpacket;
    assign w_req1  = in1_valid &  in1_startofpacket;
    assign w_drop0 = in0_valid & ~in0_startofpacket;
    assign w_drop1 = in1_valid & ~in1_startofpacket;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        in0_ready        = 1'b0;
        in1_ready        = 1'b0;
        w_s_valid        = 1'b0;
        w_s_beat         = w_beat0;
        w_drop_inc       = 2'd0;
        w_pkt_inc0       = 1'b0;
        w_pkt_inc1       = 1'b0;
        case (r_state)
            IDLE: begin
                // Stray beats are swallowed here; SOP beats wait for the grant cycle.
                in0_ready  = w_drop0;
                in1_ready  = w_drop1;
                w_drop_inc = {1'b0, w_drop0} + {1'b0, w_drop1};
                if (w_req0 && w_req1) begin
                    if (r_last_grant) begin
                        w_state_nxt      = OWN0;
                        w_last_grant_nxt = 1'b0;
                    end else begin
                        w_state_nxt      = OWN1;
                        w_last_grant_nxt = 1'b1;
                    end
                end else if (w_req0) begin
                    w_state_nxt = OWN0;
                end else if (w_req1) begin
                    w_state_nxt = OWN1;
                end
            end
            OWN0: begin
                in0_ready = w_s_ready;
                w_s_valid = in0_valid;
                w_s_beat  = w_beat0;
                if (in0_valid && w_s_ready && in0_endofpacket) begin
                    w_pkt_inc0  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            OWN1: begin
                in1_ready = w_s_ready;
                w_s_valid = in1_valid;
                w_s_beat  = w_beat1;
                if (in1_valid && w_s_ready && in1_endofpacket) begin
                    w_pkt_inc1  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_drop_sum = {1'b0, r_drop_cnt} + {{(CNT_W-1){1'b0}}, w_drop_inc};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pkt_cnt0 <= '0;
            r_pkt_cnt1 <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_pkt_inc0) r_pkt_cnt0 <= r_pkt_cnt0 + 1'b1;
            if (w_pkt_inc1) r_pkt_cnt1 <= r_pkt_cnt1 + 1'b1;
            r_drop_cnt <= w_drop_sum[CNT_W] ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];
        end
    end

    sonic_eth_10g_st_pipe_stage u_out_stage (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_s_valid (w_s_valid),
        .o_s_ready (w_s_ready),
        .i_s_beat  (w_s_beat),
        .o_m_valid (out_valid),
        .i_m_ready (out_ready),
        .o_m_beat  (w_out_beat)
    );

    assign out_data          = w_out_beat.data;
    assign out_error         = w_out_beat.error;
    assign out_startofpacket = w_out_beat.sop;
    assign out_endofpacket   = w_out_beat.eop;
    assign out_empty         = w_out_beat.empty;
    assign pkt_cnt0          = r_pkt_cnt0;
    assign pkt_cnt1          = r_pkt_cnt1;
    assign drop_cnt          = r_drop_cnt;
    assign owner             = state_to_owner(r_state);

endmodule

// File: tb/tb_sonic_eth_10g_tx_frame_arbiter.sv
// tb/tb_sonic_eth_10g_tx_frame_arbiter.sv - self-checking bench for the TX frame arbiter
module tb_sonic_eth_10g_tx_frame_arbiter;
    import sonic_eth_10g_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in0_valid, in0_ready, in0_startofpacket, in0_endofpacket;
    logic        in1_valid, in1_ready, in1_startofpacket, in1_endofpacket;
    logic [63:0] in0_data, in1_data, out_data;
    logic [2:0]  in0_error, in1_error, in0_empty, in1_empty, out_error, out_empty;
    logic        out_valid, out_ready, out_startofpacket, out_endofpacket;
    logic [15:0] pkt_cnt0, pkt_cnt1, drop_cnt;
    logic [1:0]  owner;

    always #5 clk = ~clk;

    sonic_eth_10g_tx_frame_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data), .in0_error(in0_error),
        .in0_startofpacket(in0_startofpacket), .in0_endofpacket(in0_endofpacket), .in0_empty(in0_empty),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data), .in1_error(in1_error),
        .in1_startofpacket(in1_startofpacket), .in1_endofpacket(in1_endofpacket), .in1_empty(in1_empty),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_error(out_error),
        .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket), .out_empty(out_empty),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .drop_cnt(drop_cnt), .owner(owner)
    );

    typedef struct {
        logic v0, s0, v1, s1;
        logic r0, r1;
        int   inc;
    } vec_t;

    vec_t        tbl[8];
    int          n_checks = 0;
    int          n_errs   = 0;
    st_beat_t    src0[$], src1[$], expq[$];
    bit          manual;
    logic        mv0, ms0, mv1, ms1;
    logic        smp_rdy0, smp_rdy1;
    bit          prev_stall;
    st_beat_t    held;
    int          m_pkt0, m_pkt1;
    logic [16:0] m_drop;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic st_beat_t mk(input logic [63:0] d, input logic sop, input logic eop,
                                    input logic [2:0] emp);
        st_beat_t b;
        b.data  = d;
        b.error = d[2:0];
        b.sop   = sop;
        b.eop   = eop;
        b.empty = emp;
        return b;
    endfunction

    task automatic drive();
        if (manual) begin
            in0_valid = mv0; in0_startofpacket = ms0; in0_endofpacket = 1'b0;
            in0_data = 64'hD0D0; in0_error = 3'd0; in0_empty = 3'd0;
            in1_valid = mv1; in1_startofpacket = ms1; in1_endofpacket = 1'b0;
            in1_data = 64'hD1D1; in1_error = 3'd0; in1_empty = 3'd0;
        end else begin
            in0_valid = (src0.size() > 0);
            if (src0.size() > 0)
                {in0_data, in0_error, in0_startofpacket, in0_endofpacket, in0_empty} = src0[0];
            else
                {in0_data, in0_error, in0_startofpacket, in0_endofpacket, in0_empty} = '0;
            in1_valid = (src1.size() > 0);
            if (src1.size() > 0)
                {in1_data, in1_error, in1_startofpacket, in1_endofpacket, in1_empty} = src1[0];
            else
                {in1_data, in1_error, in1_startofpacket, in1_endofpacket, in1_empty} = '0;
        end
    endtask

    // One clock: drive, sample/score on the falling edge, return at posedge+1.
    task automatic step();
        st_beat_t ob;
        drive();
        @(negedge clk);
        smp_rdy0 = in0_ready;
        smp_rdy1 = in1_ready;
        ob = {out_data, out_error, out_startofpacket, out_endofpacket, out_empty};
        if (prev_stall) begin
            chk("stall_valid", 72'(out_valid), 72'(1));
            chk("stall_hold", ob, held);
        end
        prev_stall = out_valid && !out_ready;
        held       = ob;
        if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL unexpected_beat: got %0h expected none", ob);
            end else begin
                chk("beat", ob, expq.pop_front());
            end
        end
        if (!manual) begin
            if (in0_valid && in0_ready && src0.size() > 0) void'(src0.pop_front());
            if (in1_valid && in1_ready && src1.size() > 0) void'(src1.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_pkt(input int port, input int n, input logic [63:0] base,
                            input logic [2:0] emp);
        st_beat_t b;
        for (int i = 0; i < n; i++) begin
            b = mk(base * 64'(i + 1), i == 0, i == n - 1, (i == n - 1) ? emp : 3'd0);
            if (port == 0) src0.push_back(b);
            else           src1.push_back(b);
            expq.push_back(b);
        end
        if (port == 0) m_pkt0++;
        else           m_pkt1++;
    endtask

    task automatic drain(input int maxc);
        int k = 0;
        while ((src0.size() > 0 || src1.size() > 0 || expq.size() > 0 || out_valid) && k < maxc) begin
            step();
            k++;
        end
        chk("drain_done", 72'(k < maxc), 72'(1));
    endtask

    task automatic drop_model(input int inc);
        m_drop = m_drop + 17'(inc);
        if (m_drop > 17'h0FFFF) m_drop = 17'h0FFFF;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};

        manual = 0; prev_stall = 0; m_pkt0 = 0; m_pkt1 = 0; m_drop = '0;
        mv0 = 0; ms0 = 0; mv1 = 0; ms1 = 0;
        reset_n = 1'b0;
        out_ready = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 72'(out_valid), 72'(0));
        chk("rst_owner", 72'(owner), 72'(0));
        chk("rst_payload", {out_data, out_error, out_startofpacket, out_endofpacket, out_empty}, 72'(0));
        chk("rst_cnts", {pkt_cnt0, pkt_cnt1, drop_cnt}, 72'(0));
        chk("rst_ready", {in0_ready, in1_ready}, 72'(0));
        reset_n = 1'b1;

        // 3-beat port0 packet: grant at N+1, first beat visible at N+2.
        push_pkt(0, 3, 64'h11, 3'd5);
        step();
        chk("a_owner_grant", 72'(owner), 72'(2'b01));
        chk("a_bubble", 72'(out_valid), 72'(0));
        step();
        chk("a_first_valid", {out_valid, out_startofpacket, out_data}, {2'b11, 64'h11});
        step();
        step();
        chk("a_last", {out_valid, out_endofpacket, out_empty}, {2'b11, 3'd5});
        chk("a_owner_idle", 72'(owner), 72'(0));
        chk("a_pkt_cnt0", 72'(pkt_cnt0), 72'(m_pkt0));
        step();
        chk("a_out_clear", 72'(out_valid), 72'(0));
        chk("a_exp_empty", 72'(expq.size()), 72'(0));

        // Simultaneous requests: port0 first after reset, then port1 next time.
        push_pkt(0, 2, 64'hA0, 3'd1);
        push_pkt(1, 2, 64'hB0, 3'd2);
        step();
        chk("b_owner_first", 72'(owner), 72'(2'b01));
        drain(40);
        chk("b_cnts1", {pkt_cnt0, pkt_cnt1}, {16'(m_pkt0), 16'(m_pkt1)});
        push_pkt(1, 2, 64'hC0, 3'd3);
        push_pkt(0, 2, 64'hD0, 3'd4);
        step();
        chk("b_owner_rr", 72'(owner), 72'(2'b10));
        drain(40);
        chk("b_cnts2", {pkt_cnt0, pkt_cnt1}, {16'(m_pkt0), 16'(m_pkt1)});

        // Port1 packet under output backpressure.
        push_pkt(1, 4, 64'hE0, 3'd6);
        begin
            logic pat[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
            for (int i = 0; i < 6; i++) begin
                out_ready = pat[i];
                step();
                if (i >= 3) chk("c_in1_ready", 72'(smp_rdy1), 72'(pat[i]));
            end
        end
        out_ready = 1'b1;
        drain(40);
        chk("c_pkt_cnt1", 72'(pkt_cnt1), 72'(m_pkt1));

        // Stray beats in IDLE, table driven.
        manual = 1;
        for (int i = 0; i < 8; i++) begin
            mv0 = tbl[i].v0; ms0 = tbl[i].s0; mv1 = tbl[i].v1; ms1 = tbl[i].s1;
            step();
            drop_model(tbl[i].inc);
            chk($sformatf("d_ready[%0d]", i), {smp_rdy0, smp_rdy1}, {tbl[i].r0, tbl[i].r1});
            chk($sformatf("d_drop[%0d]", i), 72'(drop_cnt), 72'(m_drop));
            chk($sformatf("d_idle[%0d]", i), {owner, out_valid}, 72'(0));
        end
        mv0 = 1; ms0 = 0; mv1 = 1; ms1 = 0;
        begin
            int k = 0;
            while (m_drop < 17'd65532 && k < 40000) begin
                step();
                drop_model(2);
                k++;
            end
        end
        chk("d_near_sat", 72'(drop_cnt), 72'(m_drop));
        for (int i = 0; i < 2; i++) begin
            step();
            drop_model(2);
            chk("d_sat2", 72'(drop_cnt), 72'(m_drop));
        end
        mv1 = 0;
        step();
        drop_model(1);
        chk("d_sat1", 72'(drop_cnt), 72'(16'hFFFF));
        mv0 = 0;
        manual = 0;
        step();

        // Back-to-back single-beat packets alternate with one IDLE bubble each.
        for (int i = 0; i < 3; i++) begin
            push_pkt(0, 1, 64'h100 + 64'(i), 3'(i));
            push_pkt(1, 1, 64'h200 + 64'(i), 3'(i + 3));
        end
        for (int k = 0; k < 12; k++) begin
            step();
            chk($sformatf("e_owner[%0d]", k), 72'(owner),
                72'((k % 2 == 1) ? 2'b00 : (((k / 2) % 2 == 0) ? 2'b01 : 2'b10)));
        end
        drain(20);
        chk("e_cnts", {pkt_cnt0, pkt_cnt1}, {16'(m_pkt0), 16'(m_pkt1)});

        // Reset asserted while beat 2 of a 4-beat port0 packet is on the output.
        begin
            st_beat_t b;
            for (int i = 0; i < 4; i++) begin
                b = mk(64'h300 + 64'(i), i == 0, i == 3, 3'd0);
                src0.push_back(b);
                if (i == 0) expq.push_back(b);
            end
        end
        step();
        step();
        step();
        reset_n = 1'b0;
        #1;
        chk("f_rst_out", {out_valid, owner}, 72'(0));
        chk("f_rst_cnts", {pkt_cnt0, pkt_cnt1, drop_cnt}, 72'(0));
        src0.delete();
        prev_stall = 0;
        m_pkt0 = 0; m_pkt1 = 0; m_drop = '0;
        step();
        step();
        reset_n = 1'b1;
        push_pkt(1, 3, 64'hF0, 3'd7);
        drain(40);
        chk("f_after_cnts", {pkt_cnt0, pkt_cnt1}, {16'(m_pkt0), 16'(m_pkt1)});
        chk("f_exp_empty", 72'(expq.size()), 72'(0));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
